// File: rtl/mqnic_rx_queue_map_req_pkg.sv
// Shared constants and helpers for the RX queue mapper request path:
// mapper field widths, reorder depth and the slot-index to tag conversion.
package mqnic_rx_queue_map_req_pkg;

    localparam int MAP_QUEUE_INDEX_WIDTH = 10;
    localparam int MAP_HASH_WIDTH        = 32;
    localparam int MAP_TAG_WIDTH         = 8;
    localparam int MAP_SLOT_ADDR_WIDTH   = 4;

    function automatic int slotDepth(input int slotBits);
        return 1 << slotBits;
    endfunction

    // A tag is the slot index with all bits above the slot address forced to zero.
    function automatic logic [31:0] slotToTag(input logic [31:0] slot, input int slotBits);
        return slot & ((32'd1 << slotBits) - 32'd1);
    endfunction

endpackage

// File: rtl/mqnic_rx_queue_map_rob.sv
// Reorder buffer for mapper responses: slot allocation, tag validation,
// in-order release of mapped queues, occupancy and tag-error tracking.
module mqnic_rx_queue_map_rob
    import mqnic_rx_queue_map_req_pkg::*;
#(
    parameter int QUEUE_INDEX_WIDTH = MAP_QUEUE_INDEX_WIDTH,
    parameter int ID_WIDTH          = 1,
    parameter int TAG_WIDTH         = MAP_TAG_WIDTH,
    parameter int SLOT_ADDR_WIDTH   = MAP_SLOT_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [ID_WIDTH-1:0]          i_pushId,
    output logic [SLOT_ADDR_WIDTH-1:0]   o_pushSlot,
    output logic                         o_canAccept,
    input  logic                         i_respValid,
    input  logic [TAG_WIDTH-1:0]         i_respTag,
    input  logic [QUEUE_INDEX_WIDTH-1:0] i_respQueue,
    output logic                         o_headValid,
    output logic [QUEUE_INDEX_WIDTH-1:0] o_headQueue,
    output logic [ID_WIDTH-1:0]          o_headId,
    input  logic                         i_headReady,
    output logic [SLOT_ADDR_WIDTH:0]     o_occupancy,
    output logic                         o_tagErr
);

    localparam int DEPTH = slotDepth(SLOT_ADDR_WIDTH);
    localparam logic [SLOT_ADDR_WIDTH:0] FULL_COUNT = (SLOT_ADDR_WIDTH+1)'(DEPTH);

    logic [SLOT_ADDR_WIDTH:0]     r_wrPtr;
    logic [SLOT_ADDR_WIDTH:0]     r_rdPtr;
    logic [SLOT_ADDR_WIDTH:0]     w_wrPtrNext;
    logic [SLOT_ADDR_WIDTH:0]     w_rdPtrNext;
    logic [SLOT_ADDR_WIDTH:0]     w_occNext;
    logic [DEPTH-1:0]             r_pending;
    logic [DEPTH-1:0]             r_done;
    logic [QUEUE_INDEX_WIDTH-1:0] r_queue [DEPTH];
    logic [ID_WIDTH-1:0]          r_id    [DEPTH];
    logic                         r_canAccept;
    logic                         r_tagErr;

    logic [SLOT_ADDR_WIDTH-1:0]   w_wrSlot;
    logic [SLOT_ADDR_WIDTH-1:0]   w_rdSlot;
    logic [SLOT_ADDR_WIDTH-1:0]   w_respSlot;
    logic                         w_tagHigh;
    logic                         w_respHit;
    logic                         w_respBad;
    logic                         w_headValid;
    logic                         w_pop;

    assign w_wrSlot    = r_wrPtr[SLOT_ADDR_WIDTH-1:0];
    assign w_rdSlot    = r_rdPtr[SLOT_ADDR_WIDTH-1:0];
    assign w_respSlot  = i_respTag[SLOT_ADDR_WIDTH-1:0];
    assign w_tagHigh   = (i_respTag >> SLOT_ADDR_WIDTH) != '0;
    assign w_respHit   = i_respValid && !w_tagHigh && r_pending[w_respSlot];
    assign w_respBad   = i_respValid && !w_respHit;
    assign w_headValid = r_done[w_rdSlot];
    assign w_pop       = w_headValid && i_headReady;

    assign w_wrPtrNext = r_wrPtr + {{SLOT_ADDR_WIDTH{1'b0}}, i_push};
    assign w_rdPtrNext = r_rdPtr + {{SLOT_ADDR_WIDTH{1'b0}}, w_pop};
    assign w_occNext   = w_wrPtrNext - w_rdPtrNext;

    // Ready is registered from the next occupancy so it stays low through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_canAccept <= 1'b0;
            r_tagErr    <= 1'b0;
        end else begin
            r_wrPtr     <= w_wrPtrNext;
            r_rdPtr     <= w_rdPtrNext;
            r_canAccept <= (w_occNext != FULL_COUNT);
            r_tagErr    <= r_tagErr | w_respBad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_done    <= '0;
        end else begin
            if (i_push) begin
                r_pending[w_wrSlot] <= 1'b1;
                r_done[w_wrSlot]    <= 1'b0;
            end
            if (w_respHit) begin
                r_pending[w_respSlot] <= 1'b0;
                r_done[w_respSlot]    <= 1'b1;
            end
            if (w_pop) begin
                r_done[w_rdSlot] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_id[w_wrSlot] <= i_pushId;
        end
        if (w_respHit) begin
            r_queue[w_respSlot] <= i_respQueue;
        end
    end

    assign o_pushSlot  = w_wrSlot;
    assign o_canAccept = r_canAccept;
    assign o_headValid = w_headValid;
    assign o_headQueue = w_headValid ? r_queue[w_rdSlot] : '0;
    assign o_headId    = w_headValid ? r_id[w_rdSlot] : '0;
    assign o_occupancy = r_wrPtr - r_rdPtr;
    assign o_tagErr    = r_tagErr;

endmodule

// File: rtl/mqnic_rx_queue_map_req.sv
// Request side of the RX queue mapper: tags each packet with a reorder slot,
// issues one registered request per packet and returns mapped queues in order.
module mqnic_rx_queue_map_req
    import mqnic_rx_queue_map_req_pkg::*;
#(
    parameter int PORTS             = 1,
    parameter int QUEUE_INDEX_WIDTH = MAP_QUEUE_INDEX_WIDTH,
    parameter int ID_WIDTH          = (PORTS > 1) ? $clog2(PORTS) : 1,
    parameter int DEST_WIDTH        = QUEUE_INDEX_WIDTH + 1,
    parameter int HASH_WIDTH        = MAP_HASH_WIDTH,
    parameter int TAG_WIDTH         = MAP_TAG_WIDTH,
    parameter int SLOT_ADDR_WIDTH   = MAP_SLOT_ADDR_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ID_WIDTH-1:0]          s_axis_req_id,
    input  logic [DEST_WIDTH-1:0]        s_axis_req_dest,
    input  logic [HASH_WIDTH-1:0]        s_axis_req_hash,
    input  logic                         s_axis_req_valid,
    output logic                         s_axis_req_ready,
    output logic [ID_WIDTH-1:0]          req_id,
    output logic [DEST_WIDTH-1:0]        req_dest,
    output logic [HASH_WIDTH-1:0]        req_hash,
    output logic [TAG_WIDTH-1:0]         req_tag,
    output logic                         req_valid,
    input  logic [QUEUE_INDEX_WIDTH-1:0] resp_queue,
    input  logic [TAG_WIDTH-1:0]         resp_tag,
    input  logic                         resp_valid,
    output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_resp_queue,
    output logic [ID_WIDTH-1:0]          m_axis_resp_id,
    output logic                         m_axis_resp_valid,
    input  logic                         m_axis_resp_ready,
    output logic [SLOT_ADDR_WIDTH:0]     status_occupancy,
    output logic                         status_tag_err
);

    if (SLOT_ADDR_WIDTH > TAG_WIDTH) begin : g_badTagWidth
        $error("mqnic_rx_queue_map_req: SLOT_ADDR_WIDTH must not exceed TAG_WIDTH");
    end

    logic                       w_ready;
    logic                       w_accept;
    logic [SLOT_ADDR_WIDTH-1:0] w_wrSlot;

    logic                       r_reqValid;
    logic [ID_WIDTH-1:0]        r_reqId;
    logic [DEST_WIDTH-1:0]      r_reqDest;
    logic [HASH_WIDTH-1:0]      r_reqHash;
    logic [TAG_WIDTH-1:0]       r_reqTag;

    assign w_accept = s_axis_req_valid && w_ready;

    // The mapper cannot stall, so a request only leaves once its slot is reserved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reqValid <= 1'b0;
            r_reqId    <= '0;
            r_reqDest  <= '0;
            r_reqHash  <= '0;
            r_reqTag   <= '0;
        end else begin
            r_reqValid <= w_accept;
            if (w_accept) begin
                r_reqId   <= s_axis_req_id;
                r_reqDest <= s_axis_req_dest;
                r_reqHash <= s_axis_req_hash;
                r_reqTag  <= TAG_WIDTH'(slotToTag(32'(w_wrSlot), SLOT_ADDR_WIDTH));
            end
        end
    end

    mqnic_rx_queue_map_rob #(
        .QUEUE_INDEX_WIDTH (QUEUE_INDEX_WIDTH),
        .ID_WIDTH          (ID_WIDTH),
        .TAG_WIDTH         (TAG_WIDTH),
        .SLOT_ADDR_WIDTH   (SLOT_ADDR_WIDTH)
    ) u_rob (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_accept),
        .i_pushId    (s_axis_req_id),
        .o_pushSlot  (w_wrSlot),
        .o_canAccept (w_ready),
        .i_respValid (resp_valid),
        .i_respTag   (resp_tag),
        .i_respQueue (resp_queue),
        .o_headValid (m_axis_resp_valid),
        .o_headQueue (m_axis_resp_queue),
        .o_headId    (m_axis_resp_id),
        .i_headReady (m_axis_resp_ready),
        .o_occupancy (status_occupancy),
        .o_tagErr    (status_tag_err)
    );

    assign s_axis_req_ready = w_ready;
    assign req_valid        = r_reqValid;
    assign req_id           = r_reqId;
    assign req_dest         = r_reqDest;
    assign req_hash         = r_reqHash;
    assign req_tag          = r_reqTag;

endmodule

// File: tb/tb_mqnic_rx_queue_map_req.sv
// Randomized bench for mqnic_rx_queue_map_req with a 3-cycle mapper model and
// an in-order packet scoreboard.
module tb_mqnic_rx_queue_map_req;

    localparam int QW    = 10;
    localparam int DW    = 11;
    localparam int HW    = 32;
    localparam int TW    = 8;
    localparam int SAW   = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic [0:0]    sReqId;
    logic [DW-1:0] sReqDest;
    logic [HW-1:0] sReqHash;
    logic          sReqValid;
    logic          sReqReady;
    logic [0:0]    reqId;
    logic [DW-1:0] reqDest;
    logic [HW-1:0] reqHash;
    logic [TW-1:0] reqTag;
    logic          reqValid;
    logic [QW-1:0] respQueue;
    logic [TW-1:0] respTag;
    logic          respValid;
    logic [QW-1:0] mRespQueue;
    logic [0:0]    mRespId;
    logic          mRespValid;
    logic          mRespReady;
    logic [SAW:0]  statusOccupancy;
    logic          statusTagErr;

    mqnic_rx_queue_map_req dut (
        .clk               (clk),
        .rst               (rst),
        .s_axis_req_id     (sReqId),
        .s_axis_req_dest   (sReqDest),
        .s_axis_req_hash   (sReqHash),
        .s_axis_req_valid  (sReqValid),
        .s_axis_req_ready  (sReqReady),
        .req_id            (reqId),
        .req_dest          (reqDest),
        .req_hash          (reqHash),
        .req_tag           (reqTag),
        .req_valid         (reqValid),
        .resp_queue        (respQueue),
        .resp_tag          (respTag),
        .resp_valid        (respValid),
        .m_axis_resp_queue (mRespQueue),
        .m_axis_resp_id    (mRespId),
        .m_axis_resp_valid (mRespValid),
        .m_axis_resp_ready (mRespReady),
        .status_occupancy  (statusOccupancy),
        .status_tag_err    (statusTagErr)
    );

    typedef struct {
        logic [TW-1:0] tag;
        logic [0:0]    id;
        logic [DW-1:0] dest;
        logic [HW-1:0] hash;
    } pkt_t;

    typedef struct {
        int            due;
        logic [TW-1:0] tag;
    } mapEnt_t;

    pkt_t          outExp[$];
    mapEnt_t       mapQ[$];
    logic [QW-1:0] qTable [DEPTH];
    int            acceptCnt;
    int            outCnt;
    int            testsRun;
    int            testsFailed;
    int            cyc;
    bit            mapperOn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, observed, expected);
        end
    endtask

    // Mapper model: every request is answered three cycles later with qTable[tag].
    initial begin
        respValid = 1'b0;
        respTag   = '0;
        respQueue = '0;
        cyc       = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mapperOn) begin
                respValid = 1'b0;
                if (reqValid) mapQ.push_back('{due: cyc + 3, tag: reqTag});
                if (mapQ.size() > 0 && mapQ[0].due == cyc) begin
                    mapEnt_t e;
                    e = mapQ.pop_front();
                    respValid = 1'b1;
                    respTag   = e.tag;
                    respQueue = qTable[int'(e.tag) % DEPTH];
                end
            end
        end
    end

    // One clock cycle: score handshakes seen now, advance, then check the request stage.
    task automatic tick();
        pkt_t p;
        bit   acc;
        acc = sReqValid && sReqReady;
        if (mRespValid) begin
            if (outExp.size() == 0) begin
                checkOutput("spurious_out_valid", 1, 0);
            end else begin
                checkOutput("out_queue", mRespQueue, qTable[int'(outExp[0].tag) % DEPTH]);
                checkOutput("out_id", mRespId, outExp[0].id);
            end
        end
        if (mRespValid && mRespReady && outExp.size() > 0) begin
            void'(outExp.pop_front());
            outCnt++;
        end
        if (acc) begin
            p.tag  = TW'(acceptCnt % DEPTH);
            p.id   = sReqId;
            p.dest = sReqDest;
            p.hash = sReqHash;
            outExp.push_back(p);
            acceptCnt++;
        end
        @(posedge clk);
        #1;
        checkOutput("req_valid", reqValid, acc);
        if (acc) begin
            checkOutput("req_tag", reqTag, p.tag);
            checkOutput("req_id", reqId, p.id);
            checkOutput("req_dest", reqDest, p.dest);
            checkOutput("req_hash", reqHash, p.hash);
        end
        checkOutput("occupancy", statusOccupancy, outExp.size());
        checkOutput("s_ready", sReqReady, outExp.size() < DEPTH);
    endtask

    task automatic applyStimulus(input bit valid, input bit ready);
        sReqId     = 1'($urandom);
        sReqDest   = DW'($urandom);
        sReqHash   = $urandom;
        sReqValid  = valid;
        mRespReady = ready;
        tick();
    endtask

    task automatic sendResp(input int tag, input logic [QW-1:0] q);
        respTag   = TW'(tag);
        respQueue = q;
        respValid = 1'b1;
        applyStimulus(0, 1);
        respValid = 1'b0;
    endtask

    // Asynchronous reset asserted between edges; all outputs must drop at once.
    task automatic doReset();
        sReqValid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_s_ready", sReqReady, 0);
        checkOutput("rst_req_valid", reqValid, 0);
        checkOutput("rst_req_tag", reqTag, 0);
        checkOutput("rst_req_hash", reqHash, 0);
        checkOutput("rst_m_valid", mRespValid, 0);
        checkOutput("rst_m_queue", mRespQueue, 0);
        checkOutput("rst_occupancy", statusOccupancy, 0);
        checkOutput("rst_tag_err", statusTagErr, 0);
        outExp.delete();
        acceptCnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(0, 1);
    endtask

    initial begin
        int base;
        testsRun = 0; testsFailed = 0; acceptCnt = 0; outCnt = 0;
        mapperOn = 1'b1;
        rst = 1'b1;
        sReqId = '0; sReqDest = '0; sReqHash = '0; sReqValid = 1'b0; mRespReady = 1'b0;
        for (int i = 0; i < DEPTH; i++) qTable[i] = QW'($urandom);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("init_s_ready", sReqReady, 0);
        checkOutput("init_req_valid", reqValid, 0);
        checkOutput("init_m_valid", mRespValid, 0);
        checkOutput("init_occupancy", statusOccupancy, 0);
        checkOutput("init_tag_err", statusTagErr, 0);
        rst = 1'b0;
        applyStimulus(0, 1);
        applyStimulus(0, 1);

        // Single packet through the 3-cycle mapper
        qTable[0] = 10'h012;
        sReqId = 1'b0; sReqDest = 11'h005; sReqHash = 32'hDEADBEEF; sReqValid = 1'b1; mRespReady = 1'b1;
        tick();
        sReqValid = 1'b0;
        tick(); tick(); tick();
        checkOutput("single_not_early", mRespValid, 0);
        tick();
        checkOutput("single_valid", mRespValid, 1);
        checkOutput("single_queue", mRespQueue, 10'h012);
        checkOutput("single_id", mRespId, 0);
        applyStimulus(0, 1);

        // Fill with consumer stalled
        doReset();
        for (int i = 0; i < DEPTH; i++) qTable[i] = QW'($urandom);
        base = acceptCnt;
        for (int i = 0; i < 20; i++) applyStimulus(1, 0);
        checkOutput("fill_accepted", acceptCnt - base, 16);
        checkOutput("fill_s_ready", sReqReady, 0);
        checkOutput("fill_occupancy", statusOccupancy, 16);
        repeat (6) applyStimulus(0, 0);
        for (int i = 0; i < 300 && (acceptCnt - base < 20 || outExp.size() > 0); i++)
            applyStimulus(acceptCnt - base < 20, 1);
        checkOutput("fill_total_accepted", acceptCnt - base, 20);
        checkOutput("fill_drained", statusOccupancy, 0);
        repeat (4) applyStimulus(0, 1);

        // Out-of-order responses driven by hand
        mapperOn = 1'b0;
        respValid = 1'b0;
        base = acceptCnt % DEPTH;
        qTable[base] = 10'h010;
        qTable[(base + 1) % DEPTH] = 10'h020;
        qTable[(base + 2) % DEPTH] = 10'h030;
        repeat (3) applyStimulus(1, 1);
        applyStimulus(0, 1);
        sendResp((base + 2) % DEPTH, 10'h030);
        applyStimulus(0, 1);
        checkOutput("reorder_hold", mRespValid, 0);
        sendResp(base, 10'h010);
        checkOutput("reorder_first_valid", mRespValid, 1);
        checkOutput("reorder_first", mRespQueue, 10'h010);
        sendResp((base + 1) % DEPTH, 10'h020);
        checkOutput("reorder_second", mRespQueue, 10'h020);
        applyStimulus(0, 1);
        checkOutput("reorder_third", mRespQueue, 10'h030);
        applyStimulus(0, 1);
        checkOutput("reorder_empty", statusOccupancy, 0);

        // Stray tags: unused slot, then upper tag bit set on a pending slot
        checkOutput("stray_err_before", statusTagErr, 0);
        sendResp(5, 10'h055);
        checkOutput("stray_unused_err", statusTagErr, 1);
        checkOutput("stray_unused_occ", statusOccupancy, 0);
        checkOutput("stray_unused_valid", mRespValid, 0);
        doReset();
        applyStimulus(1, 1);
        applyStimulus(0, 1);
        checkOutput("stray_err_cleared", statusTagErr, 0);
        sendResp(8'h10, 10'h3FF);
        checkOutput("stray_upper_err", statusTagErr, 1);
        checkOutput("stray_upper_occ", statusOccupancy, 1);
        checkOutput("stray_upper_valid", mRespValid, 0);
        sendResp(0, qTable[0]);
        repeat (2) applyStimulus(0, 1);
        checkOutput("stray_recover_occ", statusOccupancy, 0);

        // Reset with five packets in flight; their late responses are stray
        mapperOn = 1'b1;
        repeat (5) applyStimulus(1, 0);
        doReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1);
            checkOutput("late_no_valid", mRespValid, 0);
        end
        checkOutput("late_tag_err", statusTagErr, 1);
        checkOutput("late_occupancy", statusOccupancy, 0);

        // Long randomized run across many pointer wraps, queue equals tag
        for (int i = 0; i < DEPTH; i++) qTable[i] = QW'(i);
        base = acceptCnt;
        outCnt = 0;
        for (int i = 0; i < 3000 && (acceptCnt - base < 100 || outExp.size() > 0); i++)
            applyStimulus(acceptCnt - base < 100 && ($urandom % 4 != 0), 1'($urandom));
        checkOutput("wrap_accepted", acceptCnt - base, 100);
        checkOutput("wrap_outputs", outCnt, 100);
        checkOutput("wrap_occupancy", statusOccupancy, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mqnic_rx_queue_map_req.md
Name: mqnic_rx_queue_map_req

Overview:
- Request-side companion to the RX queue mapper.
- Accepts per-packet metadata (source port, app tdest, flow hash) on a ready/valid stream and allocates a reorder slot whose index becomes the request tag.
- Issues fire-and-forget requests to the mapper, captures tagged responses, and returns the mapped queue index in packet order with backpressure.
- The mapper has no ready signal, so this block guarantees by construction that every issued request has a free slot for its response.

Parameters:
- PORTS, 1, number of ingress ports.
- QUEUE_INDEX_WIDTH, 10, width of the mapped queue index.
- ID_WIDTH, $clog2(PORTS) (min 1), source port id width.
- DEST_WIDTH, QUEUE_INDEX_WIDTH+1, app tdest width; MSB is the direct-steer flag.
- HASH_WIDTH, 32, flow hash width.
- TAG_WIDTH, 8, mapper tag width.
- SLOT_ADDR_WIDTH, 4, log2 of reorder depth (DEPTH = 2**SLOT_ADDR_WIDTH). Must be <= TAG_WIDTH, else `$error` and `$finish`.

Ports:
- clk in 1: clock.
- rst in 1: reset, asynchronous, active-high.
- s_axis_req_id in ID_WIDTH: packet source port.
- s_axis_req_dest in DEST_WIDTH: app tdest.
- s_axis_req_hash in HASH_WIDTH: flow hash.
- s_axis_req_valid in 1: metadata valid.
- s_axis_req_ready out 1: metadata accepted.
- req_id out ID_WIDTH: to mapper.
- req_dest out DEST_WIDTH: to mapper.
- req_hash out HASH_WIDTH: to mapper.
- req_tag out TAG_WIDTH: to mapper, {zeros, slot index}.
- req_valid out 1: to mapper.
- resp_queue in QUEUE_INDEX_WIDTH: from mapper.
- resp_tag in TAG_WIDTH: from mapper.
- resp_valid in 1: from mapper.
- m_axis_resp_queue out QUEUE_INDEX_WIDTH: mapped queue, in order.
- m_axis_resp_id out ID_WIDTH: source port of that packet.
- m_axis_resp_valid out 1: result valid.
- m_axis_resp_ready in 1: consumer accepts.
- status_occupancy out SLOT_ADDR_WIDTH+1: slots in use.
- status_tag_err out 1: sticky flag for a bad response tag.

Behaviour:
- **Reset values:** all outputs 0. Pointers, occupancy, pending and done bits cleared. Reset asserted mid-operation discards all in-flight slots; responses arriving after reset deasserts are treated as stray (see tag error).
- **State:** wr_ptr and rd_ptr are SLOT_ADDR_WIDTH+1 bits with wrap bit. Per slot: pending bit, done bit, queue register, id register.
- **Accept:** s_axis_req_ready = (occupancy < DEPTH). It is driven from registered state only; there is no same-cycle bypass from a pop.
- On handshake in cycle N:
  - slot wr_ptr gets pending=1, done=0, id stored; wr_ptr increments.
  - Cycle N+1: req_valid=1 for exactly one cycle, with req_id/dest/hash registered copies and req_tag = slot index zero-extended.
  - Back-to-back handshakes produce back-to-back requests.
- **Response:** on resp_valid, the slot is resp_tag[SLOT_ADDR_WIDTH-1:0].
  - Upper tag bits nonzero, or slot not pending: response ignored, status_tag_err set (sticky until rst).
  - Otherwise: queue stored, pending=0, done=1.
- **Output:** m_axis_resp_valid = done[rd_ptr slot], registered. Queue and id come from the head slot.
  - On valid&&ready: done cleared, rd_ptr increments, occupancy decrements.
  - Out-of-order responses are held until the head completes.
- **Occupancy:** = wr_ptr - rd_ptr. Simultaneous accept and pop leave it unchanged.
- **Latency:** with the 3-cycle mapper, accept at N gives req at N+1, resp at N+4, and m_axis_resp_valid at N+5. Full throughput is one packet per cycle when DEPTH >= 6.
- **Same-cycle events:**
  - A response to slot S and acceptance into slot S in one cycle is impossible: S is pending, so it is not free.
  - A response to the head slot in the same cycle the head pops: the pop uses the previous state.
- **Wrap:** pointers wrap modulo 2*DEPTH. Full when occupancy == DEPTH, empty when 0.

Decomposition:
- Shared package holds:
  - slot-index/tag helper constants (SLOT_ADDR_WIDTH, DEPTH);
  - the tag zero-extension function;
  - the mapper request/response field widths shared with the queue mapper.
- One sub-module, mqnic_rx_queue_map_rob, containing:
  - slot arrays (pending/done/queue/id);
  - pointers and occupancy;
  - tag validation.
- The top level contains the request register stage and the output interface.

Test Plan:
- Single packet: id=0, dest=0x005, hash=0xDEADBEEF, with a model mapper at 3-cycle latency returning queue 0x12.
  - Expect req_tag=0x00 one cycle after accept.
  - Expect m_axis_resp_queue=0x12, id=0 five cycles after accept.
- Fill, SLOT_ADDR_WIDTH=4, m_ready=0: 20 back-to-back inputs.
  - Expect exactly 16 accepted, s_ready=0, occupancy=16.
  - Raise m_ready: 16 outputs in tag order 0..15, then the remaining 4 are accepted.
- Reorder: mapper returns tags 2,0,1 with queues 0x30,0x10,0x20.
  - Expect no output until tag 0 arrives.
  - Expect outputs 0x10,0x20,0x30 in order.
- Stray tag: inject resp_tag=0x05 with no slot pending, and separately resp_tag=0x10 (upper bit set).
  - Expect both ignored, status_tag_err=1, occupancy unchanged.
- Async reset mid-flight: 5 packets outstanding, assert rst between clock edges.
  - Expect all outputs 0 immediately.
  - Late responses set status_tag_err, and no m_axis_resp_valid occurs.
- Wrap: 100 packets at random m_ready (50%), constant map queue=tag.
  - Expect in-order output with no loss or duplication, and occupancy back to 0 at the end.
